// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer scheduler and its channels.
package timer_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CH_W   = 2;
  localparam int unsigned DEF_PRE_W  = 16;
  localparam int unsigned DEF_PER_W  = 32;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counts prescaled strobes up to its period and pulses tick on wrap.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pre_stb,
  input  logic             wr,
  input  logic             en,
  input  logic             oneshot,
  input  logic [PER_W-1:0] period,
  output logic             expire_c,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  ch_state_e        state, state_nxt;
  logic [PER_W-1:0] cnt, cnt_nxt;
  logic [PER_W-1:0] per_q, per_nxt;
  logic             one_q, one_nxt;

  // Next-state: a config write always wins over an expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    per_nxt   = per_q;
    one_nxt   = one_q;
    expire_c  = 1'b0;
    if (wr) begin
      cnt_nxt = '0;
      if (en && (period != '0)) begin
        state_nxt = CH_RUN;
        per_nxt   = period;
        one_nxt   = oneshot;
      end else begin
        state_nxt = CH_IDLE;
      end
    end else if ((state == CH_RUN) && pre_stb) begin
      if (cnt == (per_q - PER_W'(1))) begin
        cnt_nxt  = '0;
        expire_c = 1'b1;
        if (one_q == MODE_ONESHOT) begin
          state_nxt = CH_DONE;
        end
      end else begin
        cnt_nxt = cnt + PER_W'(1);
      end
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CH_IDLE;
      cnt   <= '0;
      per_q <= '0;
      one_q <= MODE_PERIODIC;
      tick  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      per_q <= per_nxt;
      one_q <= one_nxt;
      tick  <= expire_c;
      busy  <= (state_nxt == CH_RUN);
      done  <= (state_nxt == CH_DONE);
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Shared prescaler feeding NUM_CH timer channels, with sticky pending flags and masked irq.
module timer_scheduler
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CH_W   = DEF_CH_W,
  parameter int unsigned PRE_W  = DEF_PRE_W,
  parameter int unsigned PER_W  = DEF_PER_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic              cfg_oneshot,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [NUM_CH-1:0] irq_ack,
  input  logic [NUM_CH-1:0] irq_mask,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] pending,
  output logic              irq
);

  logic [PRE_W-1:0]  pre_cnt, pre_nxt;
  logic              pre_stb_c;
  logic [NUM_CH-1:0] wr_c;
  logic [NUM_CH-1:0] expire_c;
  logic [NUM_CH-1:0] pending_nxt;

  // Prescaler: strobe on terminal count; an out-of-range count (after prescale shrinks) resets silently.
  always_comb begin
    pre_stb_c = (prescale < PRE_W'(2)) || (pre_cnt == (prescale - PRE_W'(1)));
    pre_nxt   = pre_cnt + PRE_W'(1);
    if (pre_stb_c || (pre_cnt >= prescale)) begin
      pre_nxt = '0;
    end
  end

  // Write decode and channel array; out-of-range channel selects match no instance.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_c[g] = cfg_we && (cfg_ch == CH_W'(g));

    timer_channel #(
      .PER_W (PER_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pre_stb  (pre_stb_c),
      .wr       (wr_c[g]),
      .en       (cfg_en),
      .oneshot  (cfg_oneshot),
      .period   (cfg_period),
      .expire_c (expire_c[g]),
      .tick     (tick[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

  // Pending: set by the expiry and held through the tick cycle so a same-cycle ack loses.
  always_comb begin
    pending_nxt = (pending & ~irq_ack) | expire_c | tick;
  end

  // Prescaler, pending and irq registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pre_cnt <= pre_nxt;
      pending <= pending_nxt;
      irq     <= |(pending & irq_mask);
    end
  end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
Multi-channel timebase controller built from one shared prescaler and NUM_CH independent channel counters. It produces per-channel one-cycle tick pulses, either periodic or one-shot, at programmable multiples of the prescaled rate. It is configured through a single-cycle write port and reports status and a maskable interrupt. It sits between the system clock domain and the display, sampling and debounce logic, which today each instantiate their own counters and dividers.

Parameters:
NUM_CH, 4, number of timer channels (1..16)
CH_W, 2, width of channel select; must be >= clog2(NUM_CH)
PRE_W, 16, width of prescaler count and prescale input
PER_W, 32, width of channel period and channel counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 forces all state to reset values immediately
prescale  input  PRE_W  prescaler modulo; 0 and 1 both mean a prescaled strobe every cycle
cfg_we  input  1  config write strobe, one cycle
cfg_ch  input  CH_W  target channel; writes with cfg_ch >= NUM_CH are ignored
cfg_en  input  1  1 = start or restart the channel, 0 = stop it
cfg_oneshot  input  1  1 = one-shot mode, 0 = periodic mode
cfg_period  input  PER_W  channel period, in prescaled strobes
irq_ack  input  NUM_CH  write-one-to-clear for pending bits
irq_mask  input  NUM_CH  1 = pending bit contributes to irq
tick  output  NUM_CH  registered one-cycle pulse per channel expiry
busy  output  NUM_CH  channel is in RUN
done  output  NUM_CH  one-shot channel has expired (DONE)
pending  output  NUM_CH  sticky expiry flags
irq  output  1  OR over (pending & irq_mask), registered

Behaviour:
- Reset (reset=0): pre_cnt=0; all channels IDLE with cnt=0, period=0, oneshot=0; tick, busy, done, pending and irq all 0.
- Prescaler: pre_cnt counts 0..prescale-1 and wraps. pre_stb = (pre_cnt==prescale-1) | (prescale<2). If prescale changes so that pre_cnt >= prescale, pre_cnt wraps to 0 on the next edge without a strobe.
- Channel FSM states: CH_IDLE, CH_RUN, CH_DONE.
  - Config write on a valid channel with cfg_en=1 and cfg_period!=0: latch period and oneshot, set cnt=0, go to RUN. This applies from any state, so a write restarts a running channel.
  - Config write with cfg_en=0 or cfg_period==0: go to IDLE with cnt=0.
  - RUN with pre_stb: if cnt==period-1, then cnt=0, tick pulses in the next cycle, and the channel goes to DONE (one-shot) or stays in RUN (periodic). Otherwise cnt=cnt+1.
  - RUN without pre_stb: hold.
  - DONE and IDLE: hold until a config write.
- Simultaneous config write and expiry on the same channel: the write wins. No tick is produced and no pending bit is set.
- Period 1 with prescale<2: a periodic channel ticks every cycle; first tick is 2 cycles after the write edge.
- Tick latency: the tick bit is high in exactly the one cycle after the edge where cnt wrapped. First tick of a periodic channel follows the period-th pre_stb after the write.
- busy = (state==RUN). done = (state==DONE). Both are registered from state.
- pending[i] is set in the same cycle tick[i] is high, and stays set until cleared by irq_ack[i]=1. If set and clear occur in the same cycle, set wins.
- irq is registered: irq = |(pending & irq_mask), lagging pending by one cycle.
- reset asserted mid-count: everything returns to reset values asynchronously. Counting resumes only after new config writes.
- All arithmetic is unsigned. cnt and period wrap-free because cnt <= period-1.

Decomposition:
- Shared package timer_pkg:
  - localparams CH_IDLE=2'd0, CH_RUN=2'd1, CH_DONE=2'd2
  - MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1
  - default widths
- One sub-module, timer_channel. It contains one FSM, the period/cnt registers and the tick register, with inputs clk, reset, pre_stb, wr, en, oneshot, period. It is instantiated NUM_CH times via generate.
- The prescaler, write decode, pending and irq logic stay in the top level.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then release with no writes for 50 cycles -> tick, busy, done, pending and irq remain 0.
- Periodic: prescale=4, write ch0 en=1 period=3 periodic -> tick[0] pulses every 12 cycles, exactly one cycle wide; busy[0]=1 throughout; pending[0] sets on the first tick.
- One-shot: prescale=1, write ch2 period=5 oneshot -> a single tick[2] 6 cycles after the write edge; then done[2]=1 and busy[2]=0; no further ticks for 100 cycles.
- Collision: with ch1 at cnt=period-1, rewrite ch1 in the same cycle pre_stb fires -> no tick[1], cnt restarts at 0, next tick a full period later. Separately, irq_ack[1]=1 in the same cycle as tick[1] -> pending[1] stays 1.
- Interrupt path: irq_mask=4'b0010 with ch0 and ch1 both ticking -> irq follows only pending[1] with one-cycle lag; irq_ack=2 -> pending[1]=0 and irq=0 on the next cycle.
- Abort and bounds: reset pulsed low mid-count -> all outputs 0 immediately. cfg_ch=3 with NUM_CH=3 -> ignored. cfg_en=1 with period=0 -> channel IDLE.
